seg7_scan_ctrl: RTL
===================

Name: seg7_scan_ctrl

Overview:
- Time-multiplexed controller for a bank of common-segment 7-segment digits.
- Shares one hex-to-7-segment decode path across NUM_DIGITS digits. Scans them round-robin with an anti-ghosting blank interval.
- Accepts new display contents through a valid/ready handshake. New contents are applied only at frame boundaries, so a frame never mixes old and new data.
- Sits between a CPU-visible register block and the board's segment/digit-enable pins.

Parameters:
- NUM_DIGITS, 8: digits scanned. Range 2..16.
- CLK_DIV, 50000: clock cycles per digit slot, blank plus drive. Must exceed BLANK_CYCLES.
- BLANK_CYCLES, 16: cycles at the start of each slot with all digits off. Range ≥1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  scan enable
- wr_valid  in  1  new display contents offered
- wr_ready  out  1  controller can accept contents
- wr_data  in  4*NUM_DIGITS  hex nibble per digit; digit k = bits [4k+3:4k]
- wr_dp  in  NUM_DIGITS  decimal point per digit
- wr_blank  in  NUM_DIGITS  1 = digit k shows nothing
- digit_sel  out  NUM_DIGITS  one-hot digit enable, active-high
- segments  out  7  segments g..a, bit0 = a, active-high
- dp  out  1  decimal point for the driven digit
- frame_done  out  1  one-cycle pulse at the end of each full scan

Behaviour:
- Reset (async assert, sync release):
  - State IDLE, idx=0, slot counter=0, pending=0.
  - Active and shadow data, dp and blank registers all cleared.
  - Outputs: digit_sel=0, segments=0, dp=0, frame_done=0, wr_ready=1.
- Handshake:
  - wr_ready = !pending.
  - Transfer when wr_valid && wr_ready: shadow <= {wr_data, wr_dp, wr_blank}; pending <= 1.
  - wr_valid with wr_ready=0 is ignored. The requester must hold it.
- Commit (active <= shadow, pending <= 0):
  - Occurs on the last DRIVE cycle of digit NUM_DIGITS-1.
  - Also occurs on any cycle in IDLE with pending=1.
  - wr_ready rises the cycle after commit. Write and commit can never coincide, because pending=1 forces wr_ready=0.
- FSM (Moore; all outputs registered and updated on the same edge that enters the state):
  - IDLE: all outputs 0, idx=0.
    - enable=1 → BLANK, counter=0.
  - BLANK: digit_sel=0, segments=0, dp=0. Lasts exactly BLANK_CYCLES cycles.
    - → DRIVE, counter=0.
  - DRIVE: digit_sel=1<<idx; dp=active_dp[idx].
    - segments = 0 if active_blank[idx], else decode(active_data nibble idx).
    - decode values for 0..F: 3F,06,5B,4F,66,6D,7D,07,7F,67,77,7C,58,5E,79,71 (hex).
    - Lasts exactly CLK_DIV-BLANK_CYCLES cycles.
    - At the last cycle, if idx==NUM_DIGITS-1: idx→0, commit if pending, frame_done=1 in the next cycle only. Otherwise idx+1. Next state BLANK.
- enable deassert in any state:
  - Next cycle IDLE, outputs 0, idx=0, counter=0.
  - No frame_done is emitted.
  - A partial frame does not commit; a pending update commits from IDLE.
- enable reasserted: scan restarts at digit 0 with a full BLANK.
- At most one bit of digit_sel is ever high. digit_sel is 0 for ≥BLANK_CYCLES cycles between any two different drive slots.
- Counter width: clog2(CLK_DIV). idx width: clog2(NUM_DIGITS). idx wraps only via the rule above.
- Reset mid-scan: outputs go to 0 immediately (async); pending data is discarded.

Test Plan (NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2):
1. Reset, then enable=1 with no writes → digit_sel sequence 0(2),1(6),0(2),2(6),0(2),4(6),0(2),8(6) cycles. segments=3F throughout drive. frame_done pulses once every 32 cycles.
2. Write wr_data=16'hA5C3, wr_dp=4'b0100, wr_blank=0 mid-frame → wr_ready low the following cycle. Current frame still shows 3F. Next frame shows digit0=4F, digit1=58, digit2=6D with dp=1, digit3=77. wr_ready back to 1 the cycle after commit.
3. wr_valid held high during pending → no second transfer until wr_ready=1. The second value appears one frame after the first.
4. wr_blank=4'b1010 → digits 1 and 3 have digit_sel asserted with segments=0 and dp=0.
5. Drop enable during digit 2 DRIVE with a pending write → all outputs 0 next cycle, no frame_done, commit in IDLE. Re-enable → starts at digit 0 after 2 blank cycles showing the new data.
6. Assert rst_n=0 asynchronously mid-DRIVE → outputs 0 before the next clk edge. After release, wr_ready=1 and state is IDLE.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scanner: one shared hex decoder, round-robin digit
// slots with a leading blank interval, and updates applied only at frame boundaries.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic [NUM_DIGITS-1:0]   wr_dp,
  input  logic [NUM_DIGITS-1:0]   wr_blank,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [6:0]              segments,
  output logic                    dp,
  output logic                    frame_done
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(CLK_DIV - BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h67;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h58;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0] shadow_data_q, shadow_data_d, active_data_q, active_data_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d, active_dp_q, active_dp_d;
  logic [NUM_DIGITS-1:0]   shadow_blank_q, shadow_blank_d, active_blank_q, active_blank_d;
  logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
  logic [6:0]              segments_q, segments_d;
  logic                    dp_q, dp_d;
  logic                    frame_done_q, frame_done_d;
  logic                    commit_s;
  logic [3:0]              nib_s;
  int unsigned             idx_int_s;

  // Scan sequencer: enable low overrides every state and parks the scan at digit 0.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    frame_done_d = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = '0;
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_DRIVE: begin
          if (cnt_q == DRIVE_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d        = '0;
              frame_done_d = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // A completed frame (frame_done_d) or an idle cycle is the only safe point to swap contents.
  assign commit_s = pending_q && ((state_q == ST_IDLE) || frame_done_d);

  // Shadow capture on handshake, shadow-to-active on commit; the two never coincide.
  always_comb begin
    pending_d      = pending_q;
    shadow_data_d  = shadow_data_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_blank_d = shadow_blank_q;
    active_data_d  = active_data_q;
    active_dp_d    = active_dp_q;
    active_blank_d = active_blank_q;
    if (wr_valid && !pending_q) begin
      shadow_data_d  = wr_data;
      shadow_dp_d    = wr_dp;
      shadow_blank_d = wr_blank;
      pending_d      = 1'b1;
    end else if (commit_s) begin
      active_data_d  = shadow_data_q;
      active_dp_d    = shadow_dp_q;
      active_blank_d = shadow_blank_q;
      pending_d      = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // Moore outputs computed from the state being entered so they register on the same edge.
  always_comb begin
    digit_sel_d = '0;
    segments_d  = 7'h00;
    dp_d        = 1'b0;
    idx_int_s   = 32'(idx_d);
    nib_s       = active_data_q[idx_int_s*4 +: 4];
    if (state_d == ST_DRIVE) begin
      digit_sel_d = SEL_ONE << idx_d;
      if (active_blank_q[idx_d]) begin
        segments_d = 7'h00;
        dp_d       = 1'b0;
      end else begin
        segments_d = hex_to_seg(nib_s);
        dp_d       = active_dp_q[idx_d];
      end
    end else begin
      digit_sel_d = '0;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Display content registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q      <= 1'b0;
      shadow_data_q  <= '0;
      shadow_dp_q    <= '0;
      shadow_blank_q <= '0;
      active_data_q  <= '0;
      active_dp_q    <= '0;
      active_blank_q <= '0;
    end else begin
      pending_q      <= pending_d;
      shadow_data_q  <= shadow_data_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_blank_q <= shadow_blank_d;
      active_data_q  <= active_data_d;
      active_dp_q    <= active_dp_d;
      active_blank_q <= active_blank_d;
    end
  end

  // Pin-facing output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_sel_q  <= '0;
      segments_q   <= 7'h00;
      dp_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      digit_sel_q  <= digit_sel_d;
      segments_q   <= segments_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign wr_ready   = ~pending_q;
  assign digit_sel  = digit_sel_q;
  assign segments   = segments_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule
